// File: rtl/cisr_row_decoder_if.sv
// Channel-side bundle between SpMV channels and the CISR row decoder.
// Carries row-length requests, per-element fetch strobes and the returned row IDs.
// master = channel side, slave = decoder side.
interface cisr_row_decoder_if #(
    parameter int DATA_W   = 32,
    parameter int CHAN_NUM = 16
);
    logic [CHAN_NUM-1:0]        row_len_valid;
    logic [CHAN_NUM*DATA_W-1:0] row_len_in;
    logic [CHAN_NUM-1:0]        row_len_ready;
    logic [CHAN_NUM-1:0]        elem_valid;
    logic [CHAN_NUM-1:0]        row_id_valid;
    logic [CHAN_NUM*DATA_W-1:0] row_id_out;
    logic                       empty_row_valid;
    logic [DATA_W-1:0]          empty_row_id;
    logic                       proto_err;
    logic                       done;

    modport master (
        output row_len_valid, row_len_in, elem_valid,
        input  row_len_ready, row_id_valid, row_id_out,
        input  empty_row_valid, empty_row_id, proto_err, done
    );

    modport slave (
        input  row_len_valid, row_len_in, elem_valid,
        output row_len_ready, row_id_valid, row_id_out,
        output empty_row_valid, empty_row_id, proto_err, done
    );
endinterface

// File: rtl/cisr_row_decoder.sv
// CISR row decoder: hands out global row IDs in channel order and tags every fetched nonzero with its row.
// Latency: row_id/empty_row outputs 1 cycle after the element/accept; row_len_ready is combinational.
// Backpressure: a channel is ready only when its row is closing/closed and IDs remain; zero-length rows granted one per cycle.
module cisr_row_decoder #(
    parameter int DATA_W   = 32,
    parameter int CHAN_NUM = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spmv_init,
    input  logic [DATA_W-1:0] num_rows,
    cisr_row_decoder_if.slave bus
);
    logic [DATA_W-1:0]          rem_q [CHAN_NUM];
    logic [DATA_W-1:0]          rem_d [CHAN_NUM];
    logic [DATA_W-1:0]          cur_q [CHAN_NUM];
    logic [DATA_W-1:0]          cur_d [CHAN_NUM];
    logic [DATA_W-1:0]          next_id_q, next_id_d;
    logic [DATA_W-1:0]          num_rows_q;
    logic [CHAN_NUM-1:0]        rid_vld_q, rid_vld_d;
    logic [CHAN_NUM*DATA_W-1:0] rid_out_q, rid_out_d;
    logic                       empty_vld_q, empty_vld_d;
    logic [DATA_W-1:0]          empty_id_q, empty_id_d;
    logic                       proto_err_q, proto_err_d;
    logic                       done_q, done_d;
    logic [CHAN_NUM-1:0]        ready_c;

    // Per-cycle loop scratch
    logic [DATA_W-1:0]          cnt;
    logic [DATA_W:0]            id_w;
    logic [DATA_W-1:0]          len;
    logic                       ev, need, rdy, acc, empty_taken, all_idle;

    // Grant row lengths in channel order, assign IDs, tag elements and track open rows
    always_comb begin
        cnt         = '0;
        id_w        = '0;
        len         = '0;
        ev          = 1'b0;
        need        = 1'b0;
        rdy         = 1'b0;
        acc         = 1'b0;
        empty_taken = 1'b0;
        ready_c     = '0;
        rid_vld_d   = '0;
        rid_out_d   = rid_out_q;
        empty_vld_d = 1'b0;
        empty_id_d  = empty_id_q;
        proto_err_d = proto_err_q;
        for (int i = 0; i < CHAN_NUM; i++) begin
            rem_d[i] = rem_q[i];
            cur_d[i] = cur_q[i];
        end

        for (int i = 0; i < CHAN_NUM; i++) begin
            len  = bus.row_len_in[i*DATA_W +: DATA_W];
            ev   = bus.elem_valid[i];
            need = (rem_q[i] == '0) || ((rem_q[i] == DATA_W'(1)) && ev);
            id_w = {1'b0, next_id_q} + {1'b0, cnt};
            // A second zero-length row in the same cycle must wait: only one empty report per cycle
            rdy  = need && (id_w < {1'b0, num_rows_q}) && !(empty_taken && (len == '0));
            acc  = rdy && bus.row_len_valid[i];
            ready_c[i] = rdy;

            // Element belonging to the currently open row (tag taken before any update)
            if (ev && (rem_q[i] != '0)) begin
                rid_vld_d[i]                  = 1'b1;
                rid_out_d[i*DATA_W +: DATA_W] = cur_q[i];
                rem_d[i]                      = rem_q[i] - DATA_W'(1);
            end

            if (acc) begin
                cnt = cnt + DATA_W'(1);
                if (len == '0) begin
                    empty_taken = 1'b1;
                    empty_vld_d = 1'b1;
                    empty_id_d  = id_w[DATA_W-1:0];
                end else begin
                    cur_d[i] = id_w[DATA_W-1:0];
                    rem_d[i] = len;
                    // With no row open, a same-cycle element is the first of the new row
                    if (ev && (rem_q[i] == '0)) begin
                        rid_vld_d[i]                  = 1'b1;
                        rid_out_d[i*DATA_W +: DATA_W] = id_w[DATA_W-1:0];
                        rem_d[i]                      = len - DATA_W'(1);
                    end
                end
            end

            if (ev && (rem_q[i] == '0) && !(acc && (len != '0))) begin
                proto_err_d = 1'b1;
            end
        end

        next_id_d = next_id_q + cnt;

        all_idle = 1'b1;
        for (int i = 0; i < CHAN_NUM; i++) begin
            if (rem_q[i] != '0) all_idle = 1'b0;
        end
        done_d = (next_id_q == num_rows_q) && all_idle && (rid_vld_q == '0) && !empty_vld_q;
    end

    // State update; reset and spmv_init both abort everything, init also loads the row count
    always_ff @(posedge clk) begin
        if (!rst_n || spmv_init) begin
            for (int i = 0; i < CHAN_NUM; i++) begin
                rem_q[i] <= '0;
                cur_q[i] <= '0;
            end
            next_id_q   <= '0;
            num_rows_q  <= (!rst_n) ? '0 : num_rows;
            rid_vld_q   <= '0;
            rid_out_q   <= '0;
            empty_vld_q <= 1'b0;
            empty_id_q  <= '0;
            proto_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            for (int i = 0; i < CHAN_NUM; i++) begin
                rem_q[i] <= rem_d[i];
                cur_q[i] <= cur_d[i];
            end
            next_id_q   <= next_id_d;
            rid_vld_q   <= rid_vld_d;
            rid_out_q   <= rid_out_d;
            empty_vld_q <= empty_vld_d;
            empty_id_q  <= empty_id_d;
            proto_err_q <= proto_err_d;
            done_q      <= done_d;
        end
    end

    assign bus.row_len_ready   = ready_c;
    assign bus.row_id_valid    = rid_vld_q;
    assign bus.row_id_out      = rid_out_q;
    assign bus.empty_row_valid = empty_vld_q;
    assign bus.empty_row_id    = empty_id_q;
    assign bus.proto_err       = proto_err_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_cisr_row_decoder.sv
// Bench for cisr_row_decoder: directed stimulus pushes expected row IDs into per-channel queues,
// a negedge monitor pops and compares whenever the decoder presents an output.
module tb_cisr_row_decoder;
    localparam int DW  = 32;
    localparam int NCH = 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          spmv_init = 1'b0;
    logic [DW-1:0] num_rows  = '0;

    cisr_row_decoder_if #(.DATA_W(DW), .CHAN_NUM(NCH)) bus ();

    cisr_row_decoder #(.DATA_W(DW), .CHAN_NUM(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spmv_init (spmv_init),
        .num_rows  (num_rows),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] exp_id [NCH][$];
    logic [DW-1:0] exp_empty [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every presented row ID / empty row must match the next expected value
    always @(negedge clk) begin
        if (rst_n && !spmv_init) begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.row_id_valid[i]) begin
                    if (exp_id[i].size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_row_id ch%0d: got %0d expected none", i, bus.row_id_out[i*DW +: DW]);
                    end else begin
                        check($sformatf("row_id_ch%0d", i), bus.row_id_out[i*DW +: DW], exp_id[i].pop_front());
                    end
                end
            end
            if (bus.empty_row_valid) begin
                if (exp_empty.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_empty_row: got %0d expected none", bus.empty_row_id);
                end else begin
                    check("empty_row_id", bus.empty_row_id, exp_empty.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.row_len_valid = '0;
        bus.row_len_in    = '0;
        bus.elem_valid    = '0;
    endtask

    task automatic do_init(input logic [DW-1:0] n);
        clr();
        spmv_init = 1'b1;
        num_rows  = n;
        step();
        spmv_init = 1'b0;
    endtask

    task automatic offer(input int ch, input logic [DW-1:0] len);
        bus.row_len_valid[ch]        = 1'b1;
        bus.row_len_in[ch*DW +: DW]  = len;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while (bus.done !== 1'b1 && c < budget) begin
            step();
            c++;
        end
        check(name, {31'd0, bus.done}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int left;
        clr();
        rst_n = 1'b0;
        repeat (2) step();
        check("rst_row_id_valid", {24'd0, bus.row_id_valid}, 0);
        check("rst_empty_valid",  {31'd0, bus.empty_row_valid}, 0);
        check("rst_proto_err",    {31'd0, bus.proto_err}, 0);
        check("rst_done",         {31'd0, bus.done}, 0);
        rst_n = 1'b1;

        // Element on channel 5 with no open row
        bus.elem_valid[5] = 1'b1;
        step();
        bus.elem_valid = '0;
        check("proto_rid_valid5", {31'd0, bus.row_id_valid[5]}, 0);
        check("proto_err_set",    {31'd0, bus.proto_err}, 1);
        step();
        check("proto_err_sticky", {31'd0, bus.proto_err}, 1);
        do_init(2);
        check("proto_err_cleared", {31'd0, bus.proto_err}, 0);

        // Single channel, lengths 3 then 2, overlapping accept and close -> 0,0,0,1,1
        offer(0, 3);
        bus.elem_valid[0] = 1'b1;
        #1 check("t1_ready_first", {31'd0, bus.row_len_ready[0]}, 1);
        exp_id[0].push_back(0);
        step();
        bus.row_len_valid[0] = 1'b0;
        exp_id[0].push_back(0);
        check("t1_not_done", {31'd0, bus.done}, 0);
        step();
        offer(0, 2);
        #1 check("t1_ready_overlap", {31'd0, bus.row_len_ready[0]}, 1);
        exp_id[0].push_back(0);
        step();
        bus.row_len_valid[0] = 1'b0;
        exp_id[0].push_back(1);
        step();
        exp_id[0].push_back(1);
        step();
        clr();
        wait_done("t1_done", 10);

        // Three channels granted together, lowest index gets lowest ID
        do_init(8);
        offer(0, 1); offer(1, 1); offer(2, 1);
        bus.elem_valid[2:0] = 3'b111;
        #1 check("t2_ready", {29'd0, bus.row_len_ready[2:0]}, 3'b111);
        exp_id[0].push_back(0);
        exp_id[1].push_back(1);
        exp_id[2].push_back(2);
        step();
        clr();
        offer(3, 1);
        bus.elem_valid[3] = 1'b1;
        #1 check("t2_ready_ch3", {31'd0, bus.row_len_ready[3]}, 1);
        exp_id[3].push_back(3);
        step();
        clr();
        step();

        // Two zero-length rows in one cycle: only the lowest channel is granted
        do_init(4);
        offer(0, 0); offer(3, 0);
        #1 check("t3_ready_ch0", {31'd0, bus.row_len_ready[0]}, 1);
        check("t3_ready_ch3_blocked", {31'd0, bus.row_len_ready[3]}, 0);
        exp_empty.push_back(0);
        step();
        bus.row_len_valid[0] = 1'b0;
        #1 check("t3_ready_ch3_retry", {31'd0, bus.row_len_ready[3]}, 1);
        exp_empty.push_back(1);
        step();
        clr();
        step();
        check("t3_no_proto", {31'd0, bus.proto_err}, 0);

        // Exhaustion: two rows, four requesters
        do_init(2);
        for (int ch = 0; ch < 4; ch++) offer(ch, 2);
        bus.elem_valid[1:0] = 2'b11;
        #1 check("t4_ready", {28'd0, bus.row_len_ready[3:0]}, 4'b0011);
        exp_id[0].push_back(0);
        exp_id[1].push_back(1);
        step();
        bus.row_len_valid[1:0] = 2'b00;
        exp_id[0].push_back(0);
        exp_id[1].push_back(1);
        #1 check("t4_ready_hi_a", {30'd0, bus.row_len_ready[3:2]}, 0);
        step();
        bus.elem_valid = '0;
        wait_done("t4_done", 10);
        check("t4_ready_hi_b", {30'd0, bus.row_len_ready[3:2]}, 0);
        clr();

        // spmv_init in the middle of a row
        do_init(8);
        offer(0, 5);
        bus.elem_valid[0] = 1'b1;
        exp_id[0].push_back(0);
        step();
        clr();
        step();
        spmv_init = 1'b1;
        num_rows  = 1;
        bus.elem_valid[0] = 1'b1;
        step();
        spmv_init = 1'b0;
        clr();
        check("t6_rid_valid_zero", {24'd0, bus.row_id_valid}, 0);
        check("t6_done_zero",      {31'd0, bus.done}, 0);
        check("t6_proto_zero",     {31'd0, bus.proto_err}, 0);
        offer(0, 1); offer(1, 1);
        bus.elem_valid[0] = 1'b1;
        #1 check("t6_ready", {30'd0, bus.row_len_ready[1:0]}, 2'b01);
        exp_id[0].push_back(0);
        step();
        clr();
        wait_done("t6_done", 10);

        step();
        left = exp_empty.size();
        for (int i = 0; i < NCH; i++) left += exp_id[i].size();
        check("scoreboard_drained", left, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
